// File: rtl/iommu_pkg.sv
// Shared IOMMU types: fault-queue record layout, cause codes and fault-queue writer states.
package iommu_pkg;

  localparam int FQ_REC_BYTES = 32;

  localparam logic [11:0] CAUSE_INST_ACCESS_FAULT  = 12'd1;
  localparam logic [11:0] CAUSE_LOAD_ACCESS_FAULT  = 12'd5;
  localparam logic [11:0] CAUSE_STORE_ACCESS_FAULT = 12'd7;
  localparam logic [11:0] CAUSE_INST_PAGE_FAULT    = 12'd12;
  localparam logic [11:0] CAUSE_LOAD_PAGE_FAULT    = 12'd13;
  localparam logic [11:0] CAUSE_STORE_PAGE_FAULT   = 12'd15;
  localparam logic [11:0] CAUSE_ALL_INBOUND_DISALW = 12'd256;
  localparam logic [11:0] CAUSE_DDT_LOAD_FAULT     = 12'd257;

  // Field order is MSB first, so cause sits in bits [11:0] of the record.
  typedef struct packed {
    logic [63:0] iotval2;
    logic [63:0] iotval;
    logic [63:0] custom;
    logic [23:0] did;
    logic [5:0]  ttyp;
    logic        priv;
    logic        pv;
    logic [19:0] pid;
    logic [11:0] cause;
  } fq_record_t;

  typedef enum logic [1:0] {
    FQ_IDLE,
    FQ_WR_REQ,
    FQ_WR_RSP
  } fq_state_e;

endpackage

// File: rtl/iommu_rr_arb.sv
// N-way round-robin arbiter: one-hot grant, pointer moves past the winner on adv_i.
module iommu_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_gnt_idx;
  logic          w_found;

  always_comb begin
    gnt_o     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(r_ptr) + i;
      if (k >= N) k = k - N;
      if (!w_found && req_i[k]) begin
        w_found   = 1'b1;
        gnt_o[k]  = 1'b1;
        w_gnt_idx = IW'(k);
      end
    end
  end

  assign any_o = w_found;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (adv_i && w_found) begin
      r_ptr <= (w_gnt_idx == IW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/iommu_fq_writer.sv
// Fault-queue writer: arbitrates fault records and writes each as one 32-byte entry at fqt.
// Optional drop counter output drop_cnt_o is enabled by defining IOMMU_FQ_DROP_CNT_EN.
module iommu_fq_writer
  import iommu_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int PPNW  = 44,
  parameter int IDXW  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SRC-1:0]     src_valid_i,
  output logic [N_SRC-1:0]     src_ready_o,
  input  logic [N_SRC*256-1:0] src_rec_i,
  input  logic                 fq_en_i,
  input  logic [PPNW-1:0]      fqb_ppn_i,
  input  logic [4:0]           fqb_log2szm1_i,
  input  logic [IDXW-1:0]      fqh_i,
  output logic [IDXW-1:0]      fqt_o,
  output logic                 fqon_o,
  output logic                 fqof_o,
  output logic                 fqmf_o,
  output logic                 fip_o,
  input  logic                 fqof_clr_i,
  input  logic                 fqmf_clr_i,
  input  logic                 fip_clr_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PPNW+11:0]     mem_req_addr_o,
  output logic [255:0]         mem_req_data_o,
  input  logic                 mem_rsp_valid_i,
  input  logic                 mem_rsp_err_i
`ifdef IOMMU_FQ_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt_o
`endif
);

  localparam int AW = PPNW + 12;

  fq_state_e        r_state;
  logic [IDXW-1:0]  r_fqt;
  logic             r_fqon, r_fqof, r_fqmf, r_fip, r_mem_valid;
  logic [AW-1:0]    r_addr;
  fq_record_t       r_rec;

  logic             w_idle, w_any, w_drop_blk, w_full;
  logic [N_SRC-1:0] w_req, w_gnt;
  logic [5:0]       w_shamt;
  logic [IDXW-1:0]  w_mask, w_fqt_inc;
  logic [AW-1:0]    w_addr;
  fq_record_t       w_rec;

  assign w_idle = (r_state == FQ_IDLE);
  assign w_req  = src_valid_i & {N_SRC{w_idle & ~rst_i}};

  iommu_rr_arb #(.N(N_SRC)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_req),
    .adv_i (w_any),
    .gnt_o (w_gnt),
    .any_o (w_any)
  );

  assign src_ready_o = w_gnt;

  // A shift of IDXW or more yields 0, so the mask degenerates to all ones.
  assign w_shamt    = {1'b0, fqb_log2szm1_i} + 6'd1;
  assign w_mask     = (IDXW'(1) << w_shamt) - IDXW'(1);
  assign w_fqt_inc  = (r_fqt + IDXW'(1)) & w_mask;
  assign w_full     = (w_fqt_inc == (fqh_i & w_mask));
  assign w_drop_blk = ~r_fqon | r_fqof | r_fqmf;
  assign w_addr     = {fqb_ppn_i, 12'b0} + (AW'(r_fqt) << $clog2(FQ_REC_BYTES));

  always_comb begin
    w_rec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i]) w_rec = src_rec_i[i*256 +: 256];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= FQ_IDLE;
      r_fqt       <= '0;
      r_fqon      <= 1'b0;
      r_fqof      <= 1'b0;
      r_fqmf      <= 1'b0;
      r_fip       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_addr      <= '0;
      r_rec       <= '0;
    end else begin
      // Clears come first so any set later in this block takes priority.
      if (fqof_clr_i) r_fqof <= 1'b0;
      if (fqmf_clr_i) r_fqmf <= 1'b0;
      if (fip_clr_i)  r_fip  <= 1'b0;
      case (r_state)
        FQ_IDLE: begin
          r_fqon <= fq_en_i;
          if (fq_en_i && !r_fqon) begin
            r_fqt  <= '0;
            r_fqof <= 1'b0;
            r_fqmf <= 1'b0;
          end
          if (w_any && !w_drop_blk) begin
            if (w_full) begin
              r_fqof <= 1'b1;
            end else begin
              r_rec       <= w_rec;
              r_addr      <= w_addr;
              r_mem_valid <= 1'b1;
              r_state     <= FQ_WR_REQ;
            end
          end
        end
        FQ_WR_REQ: begin
          if (mem_req_ready_i) begin
            r_mem_valid <= 1'b0;
            r_state     <= FQ_WR_RSP;
          end
        end
        FQ_WR_RSP: begin
          if (mem_rsp_valid_i) begin
            if (mem_rsp_err_i) begin
              r_fqmf <= 1'b1;
            end else begin
              r_fqt <= w_fqt_inc;
              r_fip <= 1'b1;
            end
            r_state <= FQ_IDLE;
          end
        end
        default: r_state <= FQ_IDLE;
      endcase
    end
  end

`ifdef IOMMU_FQ_DROP_CNT_EN
  logic        w_drop_evt;
  logic [15:0] r_drop_cnt;

  assign w_drop_evt = w_any & (w_drop_blk | w_full);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
    end else if (w_idle && fq_en_i && !r_fqon) begin
      r_drop_cnt <= {15'b0, w_drop_evt};
    end else if (w_drop_evt && r_drop_cnt != 16'hFFFF) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

  assign fqt_o           = r_fqt;
  assign fqon_o          = r_fqon;
  assign fqof_o          = r_fqof;
  assign fqmf_o          = r_fqmf;
  assign fip_o           = r_fip;
  assign mem_req_valid_o = r_mem_valid;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_data_o  = r_rec;

endmodule

// File: tb/tb_iommu_fq_writer.sv
// Directed, table-driven bench for iommu_fq_writer with hand-written multi-cycle corner cases.
module tb_iommu_fq_writer;
  import iommu_pkg::*;

  localparam int N    = 3;
  localparam int PPNW = 44;
  localparam int IDXW = 32;
  localparam int AW   = PPNW + 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     src_valid;
  logic [N-1:0]     src_ready;
  logic [N*256-1:0] src_rec;
  logic             fq_en;
  logic [PPNW-1:0]  fqb_ppn;
  logic [4:0]       log2szm1;
  logic [IDXW-1:0]  fqh;
  logic [IDXW-1:0]  fqt;
  logic             fqon, fqof, fqmf, fip;
  logic             fqof_clr, fqmf_clr, fip_clr;
  logic             req_valid, req_ready;
  logic [AW-1:0]    req_addr;
  logic [255:0]     req_data;
  logic             rsp_valid, rsp_err;
`ifdef IOMMU_FQ_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  always #5 clk = ~clk;

  iommu_fq_writer #(.N_SRC(N), .PPNW(PPNW), .IDXW(IDXW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .src_valid_i     (src_valid),
    .src_ready_o     (src_ready),
    .src_rec_i       (src_rec),
    .fq_en_i         (fq_en),
    .fqb_ppn_i       (fqb_ppn),
    .fqb_log2szm1_i  (log2szm1),
    .fqh_i           (fqh),
    .fqt_o           (fqt),
    .fqon_o          (fqon),
    .fqof_o          (fqof),
    .fqmf_o          (fqmf),
    .fip_o           (fip),
    .fqof_clr_i      (fqof_clr),
    .fqmf_clr_i      (fqmf_clr),
    .fip_clr_i       (fip_clr),
    .mem_req_valid_o (req_valid),
    .mem_req_ready_i (req_ready),
    .mem_req_addr_o  (req_addr),
    .mem_req_data_o  (req_data),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_err_i   (rsp_err)
`ifdef IOMMU_FQ_DROP_CNT_EN
    ,
    .drop_cnt_o      (drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          src;
    logic [11:0] cause;
    logic [31:0] fqh;
    logic [2:0]  clr;     // {fqof_clr, fqmf_clr, fip_clr} pulsed the cycle before
    logic        err;
    bit          wr;
    logic [55:0] addr;
    logic [31:0] fqt;
    logic        of;
    logic        mf;
    logic        fip;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int src, input logic [11:0] cause, input logic [31:0] h,
                         input logic [2:0] clr, input logic err, input bit wr,
                         input logic [55:0] addr, input logic [31:0] t,
                         input logic of, input logic mf, input logic ip);
    vec_t v;
    v.src = src; v.cause = cause; v.fqh = h; v.clr = clr; v.err = err; v.wr = wr;
    v.addr = addr; v.fqt = t; v.of = of; v.mf = mf; v.fip = ip;
    vecs.push_back(v);
  endtask

  function automatic fq_record_t mkrec(input logic [11:0] cause, input int tag);
    fq_record_t r;
    r         = '0;
    r.cause   = cause;
    r.pid     = 20'(tag * 7 + 1);
    r.pv      = 1'b1;
    r.ttyp    = 6'd1;
    r.did     = 24'h00C0DE ^ 24'(tag);
    r.custom  = 64'h0123_4567_89AB_CDEF;
    r.iotval  = 64'hDEAD_0000_0000_0000 | 64'(tag);
    r.iotval2 = {32'(tag), 32'hFEED_BEEF};
    return r;
  endfunction

  // Waits up to a bounded number of cycles for a write request.
  task automatic wait_req(output bit got);
    int n;
    n = 0;
    while (!req_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    got = req_valid;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=no_request expected=request");
    end
  endtask

  task automatic run_txn(input vec_t v, input int tag);
    fq_record_t rec;
    bit         got;
    logic       seen;
    rec  = mkrec(v.cause, tag);
    seen = 1'b0;
    if (v.clr != 3'b000) begin
      {fqof_clr, fqmf_clr, fip_clr} = v.clr;
      @(posedge clk); #1;
      {fqof_clr, fqmf_clr, fip_clr} = 3'b000;
    end
    fqh = v.fqh;
    src_rec[v.src*256 +: 256] = rec;
    src_valid = 3'(1 << v.src);
    #1 chk($sformatf("v%0d_ready", tag), 256'(src_ready), 256'(1 << v.src));
    @(posedge clk); #1;
    src_valid = '0;
    if (v.wr) begin
      wait_req(got);
      if (got) begin
        chk($sformatf("v%0d_addr", tag), 256'(req_addr), 256'(v.addr));
        chk($sformatf("v%0d_data", tag), req_data, rec);
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk($sformatf("v%0d_req_done", tag), 256'(req_valid), 256'(0));
        rsp_valid = 1'b1;
        rsp_err   = v.err;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
    end else begin
      repeat (3) begin
        if (req_valid) seen = 1'b1;
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_no_req", tag), 256'(seen), 256'(0));
    end
    chk($sformatf("v%0d_fqt", tag),  256'(fqt),  256'(v.fqt));
    chk($sformatf("v%0d_fqof", tag), 256'(fqof), 256'(v.of));
    chk($sformatf("v%0d_fqmf", tag), 256'(fqmf), 256'(v.mf));
    chk($sformatf("v%0d_fip", tag),  256'(fip),  256'(v.fip));
    chk($sformatf("v%0d_fqon", tag), 256'(fqon), 256'(1));
    $display("txn %0d src=%0d cause=%0d wr=%0b fqt=%0d fqof=%0b fqmf=%0b fip=%0b",
             tag, v.src, v.cause, v.wr, fqt, fqof, fqmf, fip);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit got;
    rst = 1'b1; src_valid = '0; src_rec = '0; fq_en = 1'b0;
    fqb_ppn = 44'h80000; log2szm1 = 5'd3; fqh = '0;
    fqof_clr = 1'b0; fqmf_clr = 1'b0; fip_clr = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;

    // Vector table: SZ=16, base 0x80000000; each row depends on the state left by the previous.
    add_vec(1, 12'd13, 0, 3'b000, 0, 1, 56'h80000000, 1, 0, 0, 1);
    add_vec(0, 12'd5,  0, 3'b000, 0, 1, 56'h80000020, 2, 0, 0, 1);
    add_vec(2, 12'd7,  0, 3'b000, 0, 1, 56'h80000040, 3, 0, 0, 1);
    add_vec(1, 12'd1,  0, 3'b000, 0, 1, 56'h80000060, 4, 0, 0, 1);
    add_vec(0, 12'd2,  0, 3'b001, 1, 1, 56'h80000080, 4, 0, 1, 0);
    add_vec(0, 12'd3,  0, 3'b000, 0, 0, 56'h0,        4, 0, 1, 0);
    add_vec(2, 12'd4,  0, 3'b010, 0, 1, 56'h80000080, 5, 0, 0, 1);
    for (int k = 5; k < 15; k++)
      add_vec(k % 3, 12'(20 + k), 0, 3'b000, 0, 1, 56'h80000000 + 56'(k * 32), 32'(k + 1), 0, 0, 1);
    add_vec(0, 12'd9,  0, 3'b000, 0, 0, 56'h0,        15, 1, 0, 1);
    add_vec(1, 12'd10, 0, 3'b000, 0, 0, 56'h0,        15, 1, 0, 1);
    add_vec(2, 12'd11, 3, 3'b100, 0, 1, 56'h800001E0, 0,  0, 0, 1);
    add_vec(0, 12'd12, 3, 3'b000, 0, 1, 56'h80000000, 1,  0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_fqt",   256'(fqt),       256'(0));
    chk("rst_fqon",  256'(fqon),      256'(0));
    chk("rst_fqof",  256'(fqof),      256'(0));
    chk("rst_fqmf",  256'(fqmf),      256'(0));
    chk("rst_fip",   256'(fip),       256'(0));
    chk("rst_req",   256'(req_valid), 256'(0));
    chk("rst_addr",  256'(req_addr),  256'(0));
    chk("rst_ready", 256'(src_ready), 256'(0));
    rst   = 1'b0;
    fq_en = 1'b1;
    @(posedge clk); #1;
    chk("en_fqon", 256'(fqon), 256'(1));

    foreach (vecs[i]) run_txn(vecs[i], i);

    // Reset while a write request is stalled.
    src_rec[255:0] = mkrec(12'd15, 99);
    src_valid = 3'b001;
    @(posedge clk); #1;
    src_valid = '0;
    chk("rstmid_req_pending", 256'(req_valid), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_req",  256'(req_valid), 256'(0));
    chk("rstmid_fqt",  256'(fqt),       256'(0));
    chk("rstmid_fip",  256'(fip),       256'(0));
    chk("rstmid_fqon", 256'(fqon),      256'(0));
    chk("rstmid_fqof", 256'(fqof),      256'(0));
    chk("rstmid_fqmf", 256'(fqmf),      256'(0));
    $display("txn rstmid req=%0b fqt=%0d fip=%0b fqon=%0b", req_valid, fqt, fip, fqon);

    // Disable while the response is outstanding: the write still retires.
    @(posedge clk); #1;
    chk("dis_fqon_up", 256'(fqon), 256'(1));
    src_rec[2*256 +: 256] = mkrec(12'd7, 100);
    src_valid = 3'b100;
    @(posedge clk); #1;
    src_valid = '0;
    wait_req(got);
    if (got) begin
      chk("dis_addr", 256'(req_addr), 256'(56'h80000000));
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
      fq_en     = 1'b0;
      rsp_valid = 1'b1;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
    end
    chk("dis_fqt",       256'(fqt),  256'(1));
    chk("dis_fip",       256'(fip),  256'(1));
    chk("dis_fqon_held", 256'(fqon), 256'(1));
    @(posedge clk); #1;
    chk("dis_fqon_down", 256'(fqon), 256'(0));
    $display("txn disable fqt=%0d fip=%0b fqon=%0b", fqt, fip, fqon);

    // Fairness: all sources requesting, queue off so every grant drops in one cycle.
    do_reset();
    src_valid = 3'b111;
    for (int k = 0; k < 9; k++) begin
      #1 chk($sformatf("rr_grant%0d", k), 256'(src_ready), 256'(1 << (k % 3)));
      $display("txn grant %0d ready=%b", k, src_ready);
      @(posedge clk); #1;
    end
    src_valid = '0;
    chk("rr_fqof", 256'(fqof),      256'(0));
    chk("rr_req",  256'(req_valid), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iommu_fq_writer.md
Name: iommu_fq_writer

Overview:
- Fault-queue controller for the RISC-V IOMMU.
- Arbitrates fault/event records (fq_record_t, 256 bit) from N internal sources: translation wrapper, CQ handler, MSI path.
- Sequences each accepted record as one 32-byte memory write into the in-memory fault queue.
- Owns the tail pointer fqt and the status bits fqon, fqof, fqmf and fip. Sits between the fault sources and the IOMMU memory write port.

Parameters:
- N_SRC, 3, number of fault-record requesters (>=1).
- PPNW, 44, physical page number width.
- IDXW, 32, width of the fqh/fqt index registers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- src_valid_i  in  N_SRC  per-source record valid
- src_ready_o  out  N_SRC  per-source accept (one-hot or zero)
- src_rec_i  in  N_SRC*256  per-source fq_record_t
- fq_en_i  in  1  fqcsr.fqen
- fqb_ppn_i  in  PPNW  queue base PPN
- fqb_log2szm1_i  in  5  log2(entries)-1
- fqh_i  in  IDXW  software head index
- fqt_o  out  IDXW  hardware tail index
- fqon_o  out  1  queue active
- fqof_o  out  1  overflow flag
- fqmf_o  out  1  memory-fault flag
- fip_o  out  1  fault interrupt pending
- fqof_clr_i, fqmf_clr_i, fip_clr_i  in  1 each  RW1C clear pulses
- mem_req_valid_o  out  1  write request valid
- mem_req_ready_i  in  1  write request accepted
- mem_req_addr_o  out  PPNW+12  byte address
- mem_req_data_o  out  256  record data
- mem_rsp_valid_i  in  1  write response
- mem_rsp_err_i  in  1  write access fault

Behaviour:
- Reset: all outputs 0; FSM in IDLE; round-robin pointer at source 0.
- Queue size: SZ = 2^(fqb_log2szm1_i+1). Index arithmetic is modulo SZ, using mask SZ-1 on IDXW bits.
- fqon_o tracks fq_en_i, updated only in IDLE. On the 0->1 transition: fqt_o<=0, fqof_o<=0, fqmf_o<=0.
- FSM states:
  - IDLE:
    - If any src_valid_i, the round-robin arbiter grants one source. src_ready_o[g]=1 combinationally in the same cycle; the record is latched.
    - Drop case: if fqon_o=0, fqof_o=1 or fqmf_o=1, the record is dropped; stay in IDLE.
    - Full case: else if ((fqt_o+1)&(SZ-1))==fqh_i&(SZ-1), set fqof_o=1 and drop the record.
    - Otherwise go to WR_REQ.
  - WR_REQ:
    - mem_req_valid_o=1; address = {fqb_ppn_i,12'b0} + fqt_o*32.
    - Address and data stay stable until mem_req_ready_i.
    - Leave for WR_RSP on valid&&ready.
  - WR_RSP:
    - Wait for mem_rsp_valid_i.
    - Error: set fqmf_o=1; fqt_o unchanged.
    - OK: fqt_o<=(fqt_o+1)&(SZ-1) and fip_o<=1.
    - Return to IDLE.
- Throughput: at most one record per 3 cycles with zero-latency memory.
- Round-robin: the grant pointer advances to the source after g, whether the record is written or dropped. No source waits more than N_SRC grants.
- Clears: each clr pulse clears its flag. If a set and a clear hit the same cycle, set wins.
- fq_en_i deasserting mid-write: the in-flight write completes, including its fqt/fip update. fqon_o drops on return to IDLE.
- rst_i mid-write: immediate return to IDLE, all outputs 0. The outstanding response is ignored.
- fqh_i is sampled only in IDLE.

Optional Feature:
- Macro: IOMMU_FQ_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt_o (16 bit), which counts records discarded by any drop case (off, full, overflow or memory fault already set).
  - The counter saturates at 16'hFFFF, is cleared by rst_i, and is cleared by the fqon 0->1 transition.
- When undefined: no port and no counter logic; drop behaviour is identical.

Decomposition:
- Add to iommu_pkg:
  - FQ_REC_BYTES=32.
  - typedef enum fq_state_e {FQ_IDLE, FQ_WR_REQ, FQ_WR_RSP}.
- fq_record_t and the CAUSE constants stay in iommu_pkg unchanged.
- One sub-module: iommu_rr_arb, a parametrized N-way round-robin arbiter with grant one-hot and an advance strobe.

Test Plan:
- Basic write:
  - Stimulus: fq_en=1, log2szm1=3 (SZ=16), fqb_ppn=0x80000, fqh=0; source 1 sends record with cause=13.
  - Expected: write addr=0x80000000 with that data; fqt_o=1; fip_o=1.
- Overflow:
  - Stimulus: SZ=16, fqh=0, fqt=15; source 0 valid.
  - Expected: record accepted and dropped; fqof_o=1; no mem_req; further records dropped until fqof_clr_i.
- Memory fault:
  - Stimulus: mem_rsp_err_i=1 on a write at fqt=4.
  - Expected: fqmf_o=1; fqt_o stays 4; fip_o unchanged.
- Fairness:
  - Stimulus: all 3 sources valid continuously for 9 grants.
  - Expected: grant order 0,1,2,0,1,2,0,1,2.
- Wrap-around:
  - Stimulus: SZ=16, fqt=15, fqh=3.
  - Expected: write addr base+0x1E0; fqt_o=0.
- Disable/reset mid-op:
  - Stimulus: mem_req_ready_i held 0 and rst_i pulsed during WR_REQ.
  - Expected: next cycle mem_req_valid_o=0 and all flags 0.
  - Stimulus: fq_en_i dropped during WR_RSP.
  - Expected: write completes, fqt increments, then fqon_o=0.
